dis_top: RTL and testbench

DIS_TOP -- requirements
Module: dis_top

---
 rtl/dis_pkg.sv | 41 ++++
 rtl/hc595_driver.sv | 106 ++++++++++
 rtl/dis_top.sv | 58 +++++
 tb/tb_dis_top.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/dis_pkg.sv
// Shared definitions for the 8-digit 74HC595 display scanner.
// Frame geometry, transfer FSM states and the active-low hex-to-segment decode.
package dis_pkg;

  localparam int FRAME_W    = 16;
  localparam int NUM_DIGITS = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT_LO = 2'd1,
    SHIFT_HI = 2'd2,
    LATCH    = 2'd3
  } state_t;

  // Common-anode segments {dp,g,f,e,d,c,b,a}, low = lit; dp stays dark.
  function automatic logic [7:0] seg_decode(input logic [3:0] nib);
    logic [7:0] seg;
    seg = 8'hFF;
    case (nib)
      4'h0: seg = 8'hC0;
      4'h1: seg = 8'hF9;
      4'h2: seg = 8'hA4;
      4'h3: seg = 8'hB0;
      4'h4: seg = 8'h99;
      4'h5: seg = 8'h92;
      4'h6: seg = 8'h82;
      4'h7: seg = 8'hF8;
      4'h8: seg = 8'h80;
      4'h9: seg = 8'h90;
      4'hA: seg = 8'h88;
      4'hB: seg = 8'h83;
      4'hC: seg = 8'hC6;
      4'hD: seg = 8'hA1;
      4'hE: seg = 8'h86;
      4'hF: seg = 8'h8E;
      default: seg = 8'hFF;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/hc595_driver.sv
// Serialises one 16-bit word MSB first into a 74HC595 chain, then pulses ST_CP.
// ST_CP rises 32*SCK_DIV cycles after start; start is ignored while busy.
module hc595_driver
  import dis_pkg::*;
#(
  parameter int SCK_DIV = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [FRAME_W-1:0] data,
  output logic               busy,
  output logic               DS,
  output logic               SH_CP,
  output logic               ST_CP
);

  localparam int               DIV_W    = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(SCK_DIV - 1);
  localparam logic [3:0]       LAST_BIT = 4'(FRAME_W - 1);

  state_t             r_state, w_state_nxt;
  logic [DIV_W-1:0]   r_div, w_div_nxt;
  logic [3:0]         r_bit, w_bit_nxt;
  logic [FRAME_W-1:0] r_shreg, w_shreg_nxt;
  logic               r_ds, r_sh_cp, r_st_cp;
  logic               w_div_done;

  assign w_div_done = (r_div == DIV_MAX);

  always_comb begin
    w_state_nxt = r_state;
    w_div_nxt   = r_div;
    w_bit_nxt   = r_bit;
    w_shreg_nxt = r_shreg;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = SHIFT_LO;
          w_shreg_nxt = data;
          w_bit_nxt   = '0;
          w_div_nxt   = '0;
        end
      end
      SHIFT_LO: begin
        if (w_div_done) begin
          w_state_nxt = SHIFT_HI;
          w_div_nxt   = '0;
        end else begin
          w_div_nxt = r_div + 1'b1;
        end
      end
      SHIFT_HI: begin
        if (w_div_done) begin
          w_div_nxt   = '0;
          w_shreg_nxt = {r_shreg[FRAME_W-2:0], 1'b0};
          if (r_bit == LAST_BIT) begin
            w_state_nxt = LATCH;
          end else begin
            w_state_nxt = SHIFT_LO;
            w_bit_nxt   = r_bit + 4'd1;
          end
        end else begin
          w_div_nxt = r_div + 1'b1;
        end
      end
      LATCH: begin
        if (w_div_done) begin
          w_state_nxt = IDLE;
          w_div_nxt   = '0;
        end else begin
          w_div_nxt = r_div + 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Pins are registered from the next state so they switch on the same edge as the FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_div   <= '0;
      r_bit   <= '0;
      r_shreg <= '0;
      r_ds    <= 1'b0;
      r_sh_cp <= 1'b0;
      r_st_cp <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_div   <= w_div_nxt;
      r_bit   <= w_bit_nxt;
      r_shreg <= w_shreg_nxt;
      r_ds    <= ((w_state_nxt == SHIFT_LO) || (w_state_nxt == SHIFT_HI)) ?
                 w_shreg_nxt[FRAME_W-1] : 1'b0;
      r_sh_cp <= (w_state_nxt == SHIFT_HI);
      r_st_cp <= (w_state_nxt == LATCH);
    end
  end

  assign busy  = (r_state != IDLE);
  assign DS    = r_ds;
  assign SH_CP = r_sh_cp;
  assign ST_CP = r_st_cp;

endmodule

// File: rtl/dis_top.sv
// Multiplexed 8-digit display scanner: one {seg,sel} frame per SCAN_DIV-cycle slot.
// First frame (digit 0) starts on the first clock edge after reset release.
module dis_top
  import dis_pkg::*;
#(
  parameter int          SCAN_DIV   = 50000,
  parameter int          SCK_DIV    = 2,
  parameter logic [31:0] DISP_VALUE = 32'h1234_5678
) (
  input  logic clk,
  input  logic rst_n,
  output logic DS,
  output logic SH_CP,
  output logic ST_CP
);

  localparam int               CNT_W   = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);
  localparam int               DIG_W   = $clog2(NUM_DIGITS);

  logic [CNT_W-1:0]   r_scan_cnt;
  logic [DIG_W-1:0]   r_digit;
  logic               w_busy;
  logic               w_start;
  logic [3:0]         w_nibble;
  logic [FRAME_W-1:0] w_frame;

  // The digit advances at the slot wrap, well after the frame for this slot has latched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scan_cnt <= '0;
      r_digit    <= '0;
    end else if (r_scan_cnt == CNT_MAX) begin
      r_scan_cnt <= '0;
      r_digit    <= r_digit + 1'b1;
    end else begin
      r_scan_cnt <= r_scan_cnt + 1'b1;
    end
  end

  assign w_start  = (r_scan_cnt == '0) && !w_busy;
  assign w_nibble = DISP_VALUE[{r_digit, 2'b00} +: 4];
  assign w_frame  = {seg_decode(w_nibble), 8'h01 << r_digit};

  hc595_driver #(
    .SCK_DIV(SCK_DIV)
  ) u_drv (
    .clk  (clk),
    .rst_n(rst_n),
    .start(w_start),
    .data (w_frame),
    .busy (w_busy),
    .DS   (DS),
    .SH_CP(SH_CP),
    .ST_CP(ST_CP)
  );

endmodule

// File: tb/tb_dis_top.sv
// Directed bench for dis_top: captures frames from the pins like a 74HC595 chain would.
module tb_dis_top;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic DS, SH_CP, ST_CP;

  int checks = 0;
  int failures = 0;

  dis_top #(.SCAN_DIV(100), .SCK_DIV(2), .DISP_VALUE(32'h1234_5678)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .DS   (DS),
    .SH_CP(SH_CP),
    .ST_CP(ST_CP)
  );

  always #10 clk = ~clk;

  // Edge index since reset release: edge 0 is the first rising edge with rst_n high.
  int cyc_cnt = 0;
  always @(posedge clk) begin
    if (!rst_n) cyc_cnt = 0;
    else cyc_cnt++;
  end

  // Pin monitor modelling the 595 chain: shift on SH_CP rise, latch on ST_CP rise.
  logic [15:0] shreg_m = '0;
  logic prev_sh = 1'b0, prev_st = 1'b0, prev_ds = 1'b0;
  int cur_bits = 0, sh_total = 0, st_total = 0, ds_viol = 0, overlap = 0, st_w = 0;
  logic [15:0] frames[$];
  int st_edges[$], sh_at_st[$], bits_q[$], widths[$];

  always @(negedge clk) begin
    if (SH_CP && !prev_sh) sh_total++;
    if (ST_CP && SH_CP) overlap++;
    if (SH_CP && prev_sh && (DS !== prev_ds)) ds_viol++;
    if (!rst_n) begin
      cur_bits = 0;
      shreg_m  = '0;
      if (ST_CP && !prev_st) st_total++;
    end else begin
      if (SH_CP && !prev_sh) begin
        shreg_m = {shreg_m[14:0], DS};
        cur_bits++;
      end
      if (ST_CP && !prev_st) begin
        frames.push_back(shreg_m);
        st_edges.push_back(cyc_cnt - 1);
        sh_at_st.push_back(sh_total);
        bits_q.push_back(cur_bits);
        cur_bits = 0;
        st_total++;
        st_w = 0;
      end
      if (ST_CP) st_w++;
      if (!ST_CP && prev_st) widths.push_back(st_w);
    end
    prev_sh = SH_CP;
    prev_st = ST_CP;
    prev_ds = DS;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int n0, st0;
    bit ok;

    // Reset held for 20 cycles: all pins low, no edges.
    repeat (20) begin
      @(negedge clk);
      #1;
      chk("reset_pins", {29'd0, DS, SH_CP, ST_CP}, 32'd0);
    end
    chk("reset_sh_edges", sh_total, 0);
    chk("reset_st_edges", st_total, 0);

    @(negedge clk);
    #1 rst_n = 1'b1;

    ok = 1'b0;
    for (int i = 0; i < 1200; i++) begin
      @(negedge clk);
      #1;
      if (frames.size() >= 9) begin
        ok = 1'b1;
        break;
      end
    end
    chk("frames_timeout", {31'd0, ok}, 32'd1);

    if (ok) begin
      chk("frame0_data", frames[0], 16'h8001);
      chk("frame0_st_edge", st_edges[0], 64);
      chk("frame0_st_width", widths[0], 2);
      chk("frame0_bits", bits_q[0], 16);
      chk("frame1_data", frames[1], 16'hF802);
      chk("frame1_st_edge", st_edges[1], 164);
      chk("frame2_data", frames[2], 16'h8204);
      chk("frame7_data", frames[7], 16'hF980);
      chk("frame7_st_edge", st_edges[7], 764);
      chk("frame8_wrap_data", frames[8], 16'h8001);
      chk("frame8_st_edge", st_edges[8], 864);
      chk("frame8_bits", bits_q[8], 16);
      chk("last_st_width", widths[widths.size()-1], 2);
      // 500-cycle window between ST_CP rises 2 and 7.
      chk("win_cycles", st_edges[7] - st_edges[2], 500);
      chk("win_sh_edges", sh_at_st[7] - sh_at_st[2], 16 * 5);
    end
    chk("ds_stable_sh_high", ds_viol, 0);
    chk("st_never_with_sh", overlap, 0);

    // Abort a frame during the bit-8 shift.
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      #1;
      if (cur_bits == 8) begin
        ok = 1'b1;
        break;
      end
    end
    chk("bit8_timeout", {31'd0, ok}, 32'd1);
    st0 = st_total;
    rst_n = 1'b0;
    #1;
    chk("midreset_pins_now", {29'd0, DS, SH_CP, ST_CP}, 32'd0);
    repeat (5) begin
      @(negedge clk);
      #1;
      chk("midreset_pins", {29'd0, DS, SH_CP, ST_CP}, 32'd0);
    end
    chk("midreset_no_latch", st_total, st0);

    @(negedge clk);
    #1 rst_n = 1'b1;
    n0 = frames.size();
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      #1;
      if (frames.size() > n0) begin
        ok = 1'b1;
        break;
      end
    end
    chk("post_reset_timeout", {31'd0, ok}, 32'd1);
    if (ok) begin
      chk("post_reset_data", frames[n0], 16'h8001);
      chk("post_reset_st_edge", st_edges[n0], 64);
      chk("post_reset_bits", bits_q[n0], 16);
    end
    chk("final_ds_stable", ds_viol, 0);
    chk("final_no_overlap", overlap, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
